lz77_enc_ctrl: RTL and testbench

Sequencer for the LZ77 encoder core. On a `start` pulse it:
- resets the encoder;
- streams the image from a synchronous ROM into the encoder's `chardata` input, one byte per cycle, with no gaps;
- buffers the emitted (offset, match_len, char_nxt) tokens in a small FIFO behind a ready/valid port;
- reports completion once the encoder finishes and the FIFO has drained.

It sits between the image ROM, the encoder core and the downstream token sink.

---
 rtl/lz77_enc_ctrl.sv | 149 ++++++++++++++
 tb/tb_lz77_enc_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_enc_ctrl.sv
// Sequencer for the LZ77 encoder: feeds the image from ROM and buffers output tokens in a FIFO.
// Optional watchdog in WAIT is built only when LZ77_CTRL_TIMEOUT_EN is defined.
module lz77_enc_ctrl #(
    parameter int IMG_LEN    = 2049,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              enc_reset,
    output logic [7:0]        enc_chardata,
    input  logic              enc_valid,
    input  logic              enc_finish,
    input  logic [3:0]        enc_offset,
    input  logic [2:0]        enc_match_len,
    input  logic [7:0]        enc_char_nxt,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [14:0]       tok_data,
    output logic [11:0]       tok_cnt,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic              err_timeout
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_LEN - 1);

    typedef enum logic [2:0] {IDLE, RST, FEED, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] feed_idx;
    logic [14:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fifo_cnt;
    logic              fifo_empty, fifo_full;
    logic              push_req, push, pop;
    logic              timeout_hit;

    always_comb begin
        fifo_empty = (fifo_cnt == '0);
        fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
        push_req   = enc_valid && (state == FEED || state == WAIT);
        pop        = !fifo_empty && tok_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push       = push_req && (!fifo_full || pop);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RST;
            RST:     state_nxt = FEED;
            FEED:    if (feed_idx == LAST) state_nxt = WAIT;
            WAIT:    if ((enc_finish && fifo_empty && !push_req) || timeout_hit) state_nxt = DONE;
            DONE:    if (start) state_nxt = RST;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ROM address runs one ahead of the byte being fed, since the ROM has one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            feed_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rom_addr <= '0;
                        feed_idx <= '0;
                    end
                end
                RST, FEED: begin
                    if (rom_addr != LAST) rom_addr <= rom_addr + 1'b1;
                    if (state == FEED)    feed_idx <= feed_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {enc_offset, enc_match_len, enc_char_nxt};
    end

    always_ff @(posedge clk) begin
        if (reset || state == RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            tok_cnt  <= '0;
            err_ovf  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: ;
            endcase
            if (push && tok_cnt != 12'hFFF) tok_cnt <= tok_cnt + 1'b1;
            if (push_req && !push)          err_ovf <= 1'b1;
        end
    end

`ifdef LZ77_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;
    logic          err_to_q;

    assign timeout_hit = (state == WAIT) && !enc_valid && (wd_cnt == TW'(TIMEOUT - 1));
    assign err_timeout = err_to_q;

    // The watchdog measures silence from the encoder: any token restarts it.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT || enc_valid) wd_cnt <= '0;
        else if (!timeout_hit)                    wd_cnt <= wd_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || state == RST) err_to_q <= 1'b0;
        else if (timeout_hit)      err_to_q <= 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT;
    assign timeout_hit        = 1'b0;
    assign err_timeout        = 1'b0;
`endif

    assign enc_reset    = (state == IDLE) || (state == RST);
    assign enc_chardata = (state == FEED) ? rom_data : 8'h00;
    assign tok_valid    = !fifo_empty;
    assign tok_data     = fifo_empty ? 15'h0 : mem[rd_ptr];
    assign busy         = (state != IDLE) && (state != DONE);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_lz77_enc_ctrl.sv
// Directed self-checking bench for lz77_enc_ctrl; the encoder is modelled by hand-driven token strobes.
// Watchdog expectations follow LZ77_CTRL_TIMEOUT_EN when the bench is built with it.
module tb_lz77_enc_ctrl;

    localparam int IMG_LEN    = 24;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 64;
`ifdef LZ77_CTRL_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              enc_reset;
    logic [7:0]        enc_chardata;
    logic              enc_valid;
    logic              enc_finish;
    logic [3:0]        enc_offset;
    logic [2:0]        enc_match_len;
    logic [7:0]        enc_char_nxt;
    logic              tok_valid;
    logic              tok_ready;
    logic [14:0]       tok_data;
    logic [11:0]       tok_cnt;
    logic              busy;
    logic              done;
    logic              err_ovf;
    logic              err_timeout;

    logic [7:0] rom [32];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    lz77_enc_ctrl #(
        .IMG_LEN(IMG_LEN), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .enc_reset(enc_reset), .enc_chardata(enc_chardata),
        .enc_valid(enc_valid), .enc_finish(enc_finish),
        .enc_offset(enc_offset), .enc_match_len(enc_match_len), .enc_char_nxt(enc_char_nxt),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
        .tok_cnt(tok_cnt), .busy(busy), .done(done),
        .err_ovf(err_ovf), .err_timeout(err_timeout)
    );

    function automatic logic [14:0] mk_tok(input int k);
        return {4'(k), 3'(k), rom[k]};
    endfunction

    task automatic applyStimulus(input logic s, input logic v, input logic fin,
                                 input logic rdy, input logic [14:0] tok);
        @(negedge clk);
        start      = s;
        enc_valid  = v;
        enc_finish = fin;
        tok_ready  = rdy;
        {enc_offset, enc_match_len, enc_char_nxt} = tok;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int pushed;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < 8; i++)  rom[i] = (i % 2 == 0) ? "A" : "B";
        for (int i = 8; i < 23; i++) rom[i] = "C";
        rom[23] = "$";

        reset = 1'b1; start = 1'b0; enc_valid = 1'b0; enc_finish = 1'b0; tok_ready = 1'b0;
        {enc_offset, enc_match_len, enc_char_nxt} = 15'h0;

        // Reset values
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_enc_reset", enc_reset, 1);
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_chardata", enc_chardata, 0);
        checkOutput("rst_tok_valid", tok_valid, 0);
        checkOutput("rst_tok_data", tok_data, 0);
        checkOutput("rst_tok_cnt", tok_cnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err_ovf", err_ovf, 0);
        checkOutput("rst_err_timeout", err_timeout, 0);
        reset = 1'b0;

        // Nominal image with sink always ready
        $display("[TB] nominal image");
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("nom_rst_enc_reset", enc_reset, 1);
        checkOutput("nom_rst_rom_addr", rom_addr, 0);
        checkOutput("nom_rst_busy", busy, 1);
        for (int k = 0; k < IMG_LEN; k++) begin
            applyStimulus(0, (k % 4 == 1), 0, 1, mk_tok(k));
            checkOutput("nom_char", enc_chardata, rom[k]);
            checkOutput("nom_enc_reset", enc_reset, 0);
            checkOutput("nom_rom_addr", rom_addr, (k + 1 > IMG_LEN - 1) ? IMG_LEN - 1 : k + 1);
            if (k > 0) begin
                checkOutput("nom_tok_valid", tok_valid, ((k - 1) % 4 == 1));
                if ((k - 1) % 4 == 1) checkOutput("nom_tok_data", tok_data, mk_tok(k - 1));
            end
        end
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("nom_wait_busy", busy, 1);
        checkOutput("nom_wait_done", done, 0);
        checkOutput("nom_wait_enc_reset", enc_reset, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("nom_done", done, 1);
        checkOutput("nom_done_busy", busy, 0);
        checkOutput("nom_tok_cnt", tok_cnt, 6);
        checkOutput("nom_err_ovf", err_ovf, 0);
        checkOutput("nom_done_enc_reset", enc_reset, 0);

        // Backpressure in WAIT with a full FIFO
        $display("[TB] backpressure");
        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("bp_rst_done", done, 0);
        checkOutput("bp_rst_enc_reset", enc_reset, 1);
        for (int k = 0; k < IMG_LEN; k++) begin
            applyStimulus(0, (k >= 20), 0, (k < 20), mk_tok(k));
            checkOutput("bp_char", enc_chardata, rom[k]);
            if (k == 0) checkOutput("bp_tok_cnt_clr", tok_cnt, 0);
        end
        for (int w = 0; w < 30; w++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput("bp_hold_valid", tok_valid, 1);
            checkOutput("bp_hold_data", tok_data, mk_tok(20));
            checkOutput("bp_hold_done", done, 0);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 1, 0);
            checkOutput("bp_pop_valid", tok_valid, 1);
            checkOutput("bp_pop_data", tok_data, mk_tok(20 + i));
            checkOutput("bp_pop_done", done, 0);
        end
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("bp_empty_valid", tok_valid, 0);
        checkOutput("bp_exit_done", done, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("bp_done", done, 1);
        checkOutput("bp_tok_cnt", tok_cnt, 4);
        checkOutput("bp_err_ovf", err_ovf, 0);

        // Overflow: sink stalled for the whole image, six tokens
        $display("[TB] overflow");
        applyStimulus(1, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);
        pushed = 0;
        for (int k = 0; k < IMG_LEN; k++) begin
            applyStimulus(0, (k >= 2 && k <= 12 && k % 2 == 0), 0, 0, mk_tok(k));
            checkOutput("ovf_err", err_ovf, (k > 10));
            checkOutput("ovf_tok_cnt", tok_cnt, (pushed > 4) ? 4 : pushed);
            if (k >= 2 && k <= 12 && k % 2 == 0) pushed++;
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 1, 0);
            checkOutput("ovf_pop_valid", tok_valid, 1);
            checkOutput("ovf_pop_data", tok_data, mk_tok(2 + 2 * i));
        end
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("ovf_exit_done", done, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("ovf_done", done, 1);
        checkOutput("ovf_err_sticky", err_ovf, 1);
        checkOutput("ovf_tok_cnt_final", tok_cnt, 4);

        // Reset asserted in FEED at k=10
        $display("[TB] reset mid-feed");
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 0; k <= 10; k++) begin
            applyStimulus(0, (k == 5), 0, 0, mk_tok(k));
            checkOutput("mr_rom_addr", rom_addr, k + 1);
        end
        checkOutput("mr_pre_tok_cnt", tok_cnt, 1);
        checkOutput("mr_pre_tok_valid", tok_valid, 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mr_enc_reset", enc_reset, 1);
        checkOutput("mr_rom_addr_clr", rom_addr, 0);
        checkOutput("mr_tok_valid", tok_valid, 0);
        checkOutput("mr_tok_cnt", tok_cnt, 0);
        checkOutput("mr_busy", busy, 0);
        checkOutput("mr_done", done, 0);
        reset = 1'b0;

        // Start pulsed at k=5 is ignored, then WAIT with a silent encoder
        $display("[TB] start while busy and silent encoder");
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        for (int k = 0; k < IMG_LEN; k++) begin
            applyStimulus((k == 5), 0, 0, 1, 0);
            checkOutput("sb_char", enc_chardata, rom[k]);
            checkOutput("sb_rom_addr", rom_addr, (k + 1 > IMG_LEN - 1) ? IMG_LEN - 1 : k + 1);
            checkOutput("sb_busy", busy, 1);
        end
        for (int w = 0; w < 80; w++) begin
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput("wd_done", done, WD_EN && (w >= TIMEOUT));
            checkOutput("wd_err_timeout", err_timeout, WD_EN && (w >= TIMEOUT));
        end
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("wd_final_done", done, 1);
        checkOutput("wd_final_tok_cnt", tok_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
